// File: rtl/riscv_run_pkg.sv
// Shared encodings for the RISC-V run monitor.
package riscv_run_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } run_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE      = 2'b00,
      CAUSE_SYSTEM    = 2'b01,
      CAUSE_SELF_LOOP = 2'b10,
      CAUSE_TIMEOUT   = 2'b11
   } done_cause_e;

   localparam logic [6:0]  OPC_SYSTEM      = 7'b1110011;
   localparam logic [31:0] INSTR_SELF_LOOP = 32'h0000006F;

endpackage

// File: rtl/run_sat_counter.sv
// Enable/clear counter that sticks at all-ones instead of wrapping.
module run_sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o,
   output logic [CNT_W-1:0] inc_c
);

   logic [CNT_W-1:0] count_q;

   // Saturating increment of the current value.
   always_comb begin
      inc_c = (&count_q) ? count_q : count_q + CNT_W'(1);
   end

   // Count register; clear wins over enable.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= inc_c;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/riscv_run_monitor.sv
// Run controller: sequences core reset, counts cycles/fetches, detects halt, captures state.
module riscv_run_monitor
   import riscv_run_pkg::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned STATE_W      = 4,
   parameter int unsigned FETCH_STATE  = 0,
   parameter int unsigned DECODE_STATE = 1,
   parameter int unsigned NUM_WATCH    = 3,
   parameter int unsigned RESET_HOLD   = 2,
   parameter int unsigned MAX_CYCLES   = 100,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [STATE_W-1:0]        cpu_state,
   input  logic [XLEN-1:0]           cpu_pc,
   input  logic [XLEN-1:0]           cpu_ir,
   input  logic [NUM_WATCH*XLEN-1:0] watch_data,
   output logic                      cpu_reset,
   output logic                      running,
   output logic                      done,
   output logic [1:0]                done_cause,
   output logic [CNT_W-1:0]          cycle_count,
   output logic [CNT_W-1:0]          fetch_count,
   output logic [XLEN-1:0]           final_pc,
   output logic [NUM_WATCH*XLEN-1:0] snapshot,
   output logic                      fetch_pulse
);

   localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam int unsigned SNAP_W = NUM_WATCH * XLEN;

   run_state_e          state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [STATE_W-1:0]  prev_state_q;
   logic                cpu_reset_q, cpu_reset_d;
   logic                running_q, running_d;
   logic                done_q, done_d;
   logic [1:0]          done_cause_q, done_cause_d;
   logic [XLEN-1:0]     final_pc_q, final_pc_d;
   logic [SNAP_W-1:0]   snapshot_q, snapshot_d;
   logic                fetch_pulse_q, fetch_pulse_d;

   logic                start_acc_c;
   logic                run_c;
   logic                fetch_entry_c;
   logic                sys_halt_c, loop_halt_c, timeout_c, halt_c;
   logic [CNT_W-1:0]    cyc_inc_c, fetch_inc_c;

   // Halt and fetch-entry detection from the core's current state.
   always_comb begin
      run_c         = (state_q == ST_RUN);
      fetch_entry_c = (cpu_state == STATE_W'(FETCH_STATE)) &&
                      ((prev_state_q != STATE_W'(FETCH_STATE)) || (cycle_count == '0));
      sys_halt_c    = (cpu_state == STATE_W'(DECODE_STATE)) && (cpu_ir[6:0] == OPC_SYSTEM);
      loop_halt_c   = (cpu_state == STATE_W'(DECODE_STATE)) && (cpu_ir == XLEN'(INSTR_SELF_LOOP));
      timeout_c     = (MAX_CYCLES != 0) && (cyc_inc_c == CNT_W'(MAX_CYCLES));
      halt_c        = sys_halt_c || loop_halt_c || timeout_c;
   end

   // Next-state logic and hold countdown.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      start_acc_c = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_HOLD;
               hold_d      = HOLD_W'(RESET_HOLD - 1);
               start_acc_c = 1'b1;
            end
         end
         ST_HOLD: begin
            if (hold_q == '0) state_d = ST_RUN;
            else              hold_d  = hold_q - HOLD_W'(1);
         end
         ST_RUN: begin
            if (halt_c) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs, including halt capture.
   always_comb begin
      cpu_reset_d   = (state_d != ST_RUN);
      running_d     = (state_d == ST_RUN);
      done_d        = (state_d == ST_DONE);
      fetch_pulse_d = run_c && fetch_entry_c;
      done_cause_d  = done_cause_q;
      final_pc_d    = final_pc_q;
      snapshot_d    = snapshot_q;
      if (start_acc_c) begin
         done_cause_d = CAUSE_NONE;
         final_pc_d   = '0;
         snapshot_d   = '0;
      end else if (run_c && halt_c) begin
         final_pc_d = cpu_pc;
         snapshot_d = watch_data;
         if (sys_halt_c)       done_cause_d = CAUSE_SYSTEM;
         else if (loop_halt_c) done_cause_d = CAUSE_SELF_LOOP;
         else                  done_cause_d = CAUSE_TIMEOUT;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         hold_q        <= '0;
         prev_state_q  <= '0;
         cpu_reset_q   <= 1'b1;
         running_q     <= 1'b0;
         done_q        <= 1'b0;
         done_cause_q  <= CAUSE_NONE;
         final_pc_q    <= '0;
         snapshot_q    <= '0;
         fetch_pulse_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         prev_state_q  <= cpu_state;
         cpu_reset_q   <= cpu_reset_d;
         running_q     <= running_d;
         done_q        <= done_d;
         done_cause_q  <= done_cause_d;
         final_pc_q    <= final_pc_d;
         snapshot_q    <= snapshot_d;
         fetch_pulse_q <= fetch_pulse_d;
      end
   end

   run_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (start_acc_c),
      .en_i    (run_c),
      .count_o (cycle_count),
      .inc_c   (cyc_inc_c)
   );

   run_sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (start_acc_c),
      .en_i    (run_c && fetch_entry_c),
      .count_o (fetch_count),
      .inc_c   (fetch_inc_c)
   );

   assign cpu_reset   = cpu_reset_q;
   assign running     = running_q;
   assign done        = done_q;
   assign done_cause  = done_cause_q;
   assign final_pc    = final_pc_q;
   assign snapshot    = snapshot_q;
   assign fetch_pulse = fetch_pulse_q;

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Directed bench for riscv_run_monitor with a stub core cycling states 0..4.
module tb_riscv_run_monitor;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [31:0]  cpu_ir;
   logic [3:0]   stub_st = '0;
   logic [31:0]  stub_pc = '0;
   logic [95:0]  watch_data;

   logic         d_cpu_reset, d_running, d_done, d_fetch_pulse;
   logic [1:0]   d_cause;
   logic [31:0]  d_cyc, d_fetch, d_pc;
   logic [95:0]  d_snap;
   logic         e_cpu_reset, e_running, e_done, e_fetch_pulse;
   logic [1:0]   e_cause;
   logic [31:0]  e_cyc, e_fetch, e_pc;
   logic [95:0]  e_snap;

   int checks = 0;
   int failures = 0;

   localparam logic [31:0] NOP    = 32'h00000013;
   localparam logic [31:0] EBREAK = 32'h00100073;
   localparam logic [31:0] JSELF  = 32'h0000006F;

   always #5 clk = ~clk;

   // Stub core: held at state 0 / pc 0 while in reset, else steps state and pc.
   always @(posedge clk) begin
      if (d_cpu_reset) begin
         stub_st <= '0;
         stub_pc <= '0;
      end else begin
         stub_st <= (stub_st == 4'd4) ? 4'd0 : stub_st + 4'd1;
         stub_pc <= stub_pc + 32'd4;
      end
   end

   assign watch_data = {32'hC0DE0000 | stub_pc, 32'hBEEF0000 | stub_pc, stub_pc};

   riscv_run_monitor #(.MAX_CYCLES(100)) dut (
      .clk(clk), .reset(reset), .start(start), .cpu_state(stub_st),
      .cpu_pc(stub_pc), .cpu_ir(cpu_ir), .watch_data(watch_data),
      .cpu_reset(d_cpu_reset), .running(d_running), .done(d_done),
      .done_cause(d_cause), .cycle_count(d_cyc), .fetch_count(d_fetch),
      .final_pc(d_pc), .snapshot(d_snap), .fetch_pulse(d_fetch_pulse)
   );

   riscv_run_monitor #(.MAX_CYCLES(12)) dut12 (
      .clk(clk), .reset(reset), .start(start), .cpu_state(stub_st),
      .cpu_pc(stub_pc), .cpu_ir(cpu_ir), .watch_data(watch_data),
      .cpu_reset(e_cpu_reset), .running(e_running), .done(e_done),
      .done_cause(e_cause), .cycle_count(e_cyc), .fetch_count(e_fetch),
      .final_pc(e_pc), .snapshot(e_snap), .fetch_pulse(e_fetch_pulse)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".cpu_reset"}, 128'(d_cpu_reset), 128'(1));
      check({tag, ".running"},   128'(d_running),   128'(0));
      check({tag, ".done"},      128'(d_done),      128'(0));
      check({tag, ".pulse"},     128'(d_fetch_pulse), 128'(0));
      check({tag, ".cause"},     128'(d_cause),     128'(0));
      check({tag, ".cyc"},       128'(d_cyc),       128'(0));
      check({tag, ".fetch"},     128'(d_fetch),     128'(0));
      check({tag, ".pc"},        128'(d_pc),        128'(0));
      check({tag, ".snap"},      128'(d_snap),      128'(0));
   endtask

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      cpu_ir = NOP;
      @(negedge clk);
      repeat (3) tick();
      check_reset_vals("rst");
      check("rst.e_cpu_reset", 128'(e_cpu_reset), 128'(1));
      reset = 1'b1;
      tick();
      check("idle.cpu_reset", 128'(d_cpu_reset), 128'(1));
      check("idle.running",   128'(d_running),   128'(0));

      // Run A: ebreak at RUN cycle 12; also start pulses during HOLD and RUN.
      do_start();
      check("h1.cpu_reset", 128'(d_cpu_reset), 128'(1));
      check("h1.running",   128'(d_running),   128'(0));
      do_start();
      check("h2.cpu_reset", 128'(d_cpu_reset), 128'(1));
      check("h2.running",   128'(d_running),   128'(0));
      tick();
      check("r1.running",   128'(d_running),   128'(1));
      check("r1.cpu_reset", 128'(d_cpu_reset), 128'(0));
      check("r1.cyc",       128'(d_cyc),       128'(0));
      check("r1.fetch",     128'(d_fetch),     128'(0));
      tick();
      check("r2.cyc",       128'(d_cyc),       128'(1));
      check("r2.pulse",     128'(d_fetch_pulse), 128'(1));
      check("r2.fetch",     128'(d_fetch),     128'(1));
      tick();
      check("r3.cyc",       128'(d_cyc),       128'(2));
      check("r3.pulse",     128'(d_fetch_pulse), 128'(0));
      do_start();
      check("r4.running",   128'(d_running),   128'(1));
      check("r4.cyc",       128'(d_cyc),       128'(3));
      repeat (8) tick();
      check("r12.cyc",      128'(d_cyc),       128'(11));
      cpu_ir = EBREAK;
      tick();
      cpu_ir = NOP;
      check("ebrk.done",      128'(d_done),      128'(1));
      check("ebrk.cause",     128'(d_cause),     128'(2'b01));
      check("ebrk.cyc",       128'(d_cyc),       128'(12));
      check("ebrk.fetch",     128'(d_fetch),     128'(3));
      check("ebrk.cpu_reset", 128'(d_cpu_reset), 128'(1));
      check("ebrk.running",   128'(d_running),   128'(0));
      check("ebrk.pc",        128'(d_pc),        128'(32'h2C));
      check("ebrk.snap",      128'(d_snap),      128'({32'hC0DE002C, 32'hBEEF002C, 32'h0000002C}));
      check("ebrk.e_cause",   128'(e_cause),     128'(2'b01));
      tick();
      check("hold.done",      128'(d_done),      128'(1));
      check("hold.cyc",       128'(d_cyc),       128'(12));
      check("hold.pc",        128'(d_pc),        128'(32'h2C));

      // Run B: self-loop on the timeout cycle of the MAX_CYCLES=12 instance.
      do_start();
      check("rs.done",      128'(d_done),      128'(0));
      check("rs.cause",     128'(d_cause),     128'(0));
      check("rs.cyc",       128'(d_cyc),       128'(0));
      check("rs.fetch",     128'(d_fetch),     128'(0));
      check("rs.pc",        128'(d_pc),        128'(0));
      check("rs.snap",      128'(d_snap),      128'(0));
      check("rs.cpu_reset", 128'(d_cpu_reset), 128'(1));
      check("rs.e_cyc",     128'(e_cyc),       128'(0));
      repeat (2) tick();
      repeat (11) tick();
      cpu_ir = JSELF;
      tick();
      cpu_ir = NOP;
      check("loop.e_done",  128'(e_done),      128'(1));
      check("loop.e_cause", 128'(e_cause),     128'(2'b10));
      check("loop.e_cyc",   128'(e_cyc),       128'(12));
      check("loop.e_pc",    128'(e_pc),        128'(32'h2C));
      check("loop.d_cause", 128'(d_cause),     128'(2'b10));

      // Run C: no halt instruction, timeout at 100 (and at 12 on the second instance).
      do_start();
      repeat (2) tick();
      for (int i = 0; i < 200; i++) begin
         if (d_done) break;
         tick();
      end
      check("to.done",    128'(d_done),    128'(1));
      check("to.cause",   128'(d_cause),   128'(2'b11));
      check("to.cyc",     128'(d_cyc),     128'(100));
      check("to.fetch",   128'(d_fetch),   128'(20));
      check("to.pc",      128'(d_pc),      128'(32'h18C));
      check("to.snap",    128'(d_snap),    128'({32'hC0DE018C, 32'hBEEF018C, 32'h0000018C}));
      check("to.e_cause", 128'(e_cause),   128'(2'b11));
      check("to.e_cyc",   128'(e_cyc),     128'(12));
      check("to.e_fetch", 128'(e_fetch),   128'(3));

      // Run D: reset for one cycle during RUN cycle 7.
      do_start();
      repeat (2) tick();
      repeat (6) tick();
      check("r7.cyc",     128'(d_cyc),     128'(6));
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check_reset_vals("midrst");
      tick();
      check("idle2.cpu_reset", 128'(d_cpu_reset), 128'(1));
      check("idle2.running",   128'(d_running),   128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/riscv_run_monitor.md
Name: riscv_run_monitor

Overview:
- Synthesizable run controller for the multi-cycle RISC-V core; replaces fixed bench-side reset and cycle-count sequencing.
- Sequences the core's reset on a start request, then counts cycles and instruction fetches.
- Detects halt: SYSTEM opcode (ecall/ebreak), a `jal x0,0` self-loop, or a cycle-budget timeout.
- Freezes the core and captures final PC plus a parametrised set of watched register values.
- Sits beside the core at top level; benches and an FPGA wrapper read its outputs.

Parameters:
- XLEN, 32, datapath width of PC, IR and watched registers
- STATE_W, 4, width of the core state encoding
- FETCH_STATE, 0, core state code for instruction fetch
- DECODE_STATE, 1, core state code in which the IR is valid
- NUM_WATCH, 3, number of watched architectural registers
- RESET_HOLD, 2, cycles the core reset is held after start (minimum 1)
- MAX_CYCLES, 100, RUN-cycle budget; 0 disables the timeout
- CNT_W, 32, width of the counters; MAX_CYCLES < 2^CNT_W

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to (re)start a run
- cpu_state  in  STATE_W  core FSM state
- cpu_pc  in  XLEN  core PC
- cpu_ir  in  XLEN  core instruction register
- watch_data  in  NUM_WATCH*XLEN  watched registers, entry k at bits [k*XLEN +: XLEN]
- cpu_reset  out  1  active-high reset driven to the core
- running  out  1  high in RUN
- done  out  1  high in DONE
- done_cause  out  2  00 none, 01 SYSTEM halt, 10 self-loop, 11 timeout
- cycle_count  out  CNT_W  RUN cycles elapsed
- fetch_count  out  CNT_W  fetches issued
- final_pc  out  XLEN  PC captured at halt
- snapshot  out  NUM_WATCH*XLEN  watch_data captured at halt
- fetch_pulse  out  1  one-cycle pulse on each fetch entry

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM goes to IDLE; cpu_reset=1.
  - running, done, fetch_pulse = 0; done_cause = 00.
  - cycle_count, fetch_count, final_pc, snapshot = 0; prev_state register = 0.
  - Reset mid-run aborts with no capture.
- FSM states: IDLE, HOLD, RUN, DONE. All outputs are registered.
- IDLE:
  - cpu_reset=1.
  - start=1 → HOLD; clear both counters, done_cause, final_pc and snapshot; load the hold counter.
- HOLD:
  - cpu_reset=1 for exactly RESET_HOLD cycles, then → RUN.
  - start is ignored.
- RUN:
  - cpu_reset=0 and running=1.
  - cycle_count increments every RUN cycle and saturates at all-ones.
  - Fetch entry means cpu_state==FETCH_STATE and prev_state!=FETCH_STATE, or the first RUN cycle with cpu_state==FETCH_STATE. On each fetch entry, fetch_count increments (saturating) and fetch_pulse=1 on the next cycle.
  - When cpu_state==DECODE_STATE:
    - cpu_ir[6:0]==7'b1110011 gives halt cause 01.
    - Otherwise cpu_ir==32'h0000006F gives cause 10.
  - Timeout: MAX_CYCLES!=0 and the post-increment cycle_count==MAX_CYCLES gives cause 11.
  - Priority on the same cycle: 01 > 10 > 11.
  - Any halt → DONE next edge. On that edge latch final_pc=cpu_pc, snapshot=watch_data and done_cause.
  - start is ignored in RUN.
- DONE:
  - done=1, running=0, cpu_reset=1 (core frozen). Counters and captured values are held.
  - start=1 → HOLD, with the same clears as from IDLE.
- prev_state updates every cycle from cpu_state.

Decomposition:
- Shared package riscv_run_pkg holds:
  - monitor state encodings (IDLE/HOLD/RUN/DONE);
  - done_cause codes;
  - OPC_SYSTEM = 7'b1110011;
  - INSTR_SELF_LOOP = 32'h0000006F.
- One natural sub-module: run_sat_counter (CNT_W-wide enable/clear saturating counter), instantiated twice.

Test Plan:
- Reset then start with RESET_HOLD=2 → cpu_reset=1 for exactly 2 cycles after start, then running=1; cycle_count increments 1 per cycle from 0.
- Stub core cycling states 0→1→2→3→4→0 with no halt, MAX_CYCLES=100:
  - done at RUN cycle 100, done_cause=11, cycle_count=100, fetch_count=20;
  - final_pc and snapshot equal the stub values on that cycle.
- cpu_ir=32'h00100073 (ebreak) presented in DECODE_STATE at RUN cycle 12 → done next cycle, done_cause=01, cycle_count=12, cpu_reset=1.
- cpu_ir=32'h0000006F in DECODE_STATE on the same cycle the timeout hits (MAX_CYCLES=12) → done_cause=10.
- After DONE, pulse start → counters and snapshot cleared, HOLD, new run. A start pulse during RUN or HOLD has no effect.
- reset=0 for 1 cycle during RUN at cycle 7 → IDLE, all outputs at reset values, cpu_reset=1, snapshot=0.
